// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer that shares one uart_tx transmitter
//   among NREQ byte producers. It grants one requester at a time and launches
//   each byte with a single-cycle tx_start. The grant is held until the
//   transmitter reports tx_done_tick. The owner may keep the grant for up to
//   MAX_BURST consecutive bytes, and a whole burst counts as one turn.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   req          : req[i] = requester i has a byte ready
//   req_data     : byte of requester i at [i*DBIT +: DBIT]
//   ack          : one-cycle pulse, byte of requester i handed to uart_tx
//   sent         : one-cycle pulse, byte of requester i finished (stop bit done)
//   tx_start     : registered one-cycle launch pulse to uart_tx
//   tx_din       : registered byte to uart_tx, holds its value between launches
//   tx_done_tick : frame-complete tick from uart_tx
//   busy         : high from grant until the owner's last sent pulse
//   owner        : index of the current or most recent grantee
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DBIT      = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      sent,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic                 busy,
  output logic [IDW-1:0]       owner
);

  // One extra bit so the count can reach MAX_BURST itself without wrapping.
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] BURST_LIMIT = BCW'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic            tx_start_q, tx_start_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;

  logic            found;
  logic [IDW-1:0]  winner;
  logic [NREQ-1:0] owner_oh;

  // Round-robin search: start just after the last finished grant and take
  // the first requester found. Scanning offsets 1..NREQ means the previous
  // owner is considered last.
  always_comb begin : rr_pick
    int idx;
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin : next_state
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    tx_start_d   = 1'b0;
    tx_din_d     = tx_din_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = S_LAUNCH;
          // tx_start/tx_din are registered, so they are loaded on the edge
          // that enters LAUNCH and are therefore valid during LAUNCH.
          tx_start_d  = 1'b1;
          tx_din_d    = req_data[int'(winner)*DBIT +: DBIT];
        end
      end
      S_LAUNCH: begin
        burst_cnt_d = burst_cnt_q + BCW'(1);
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // req[owner] matters only on the done cycle; the owner may drop it or
        // present its next byte any time before then.
        if (tx_done_tick) begin
          if (req[owner_q] && (burst_cnt_q < BURST_LIMIT)) begin
            state_d    = S_LAUNCH;
            tx_start_d = 1'b1;
            tx_din_d   = req_data[int'(owner_q)*DBIT +: DBIT];
          end else begin
            last_grant_d = owner_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      burst_cnt_q  <= '0;
      tx_start_q   <= 1'b0;
      tx_din_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      tx_start_q   <= tx_start_d;
      tx_din_q     <= tx_din_d;
    end
  end

  assign owner_oh = NREQ'(1) << owner_q;

  // ack and sent decode from the state register; gating with reset keeps a
  // frame that is dropped by reset from producing any pulse.
  assign ack      = (!reset && state_q == S_LAUNCH) ? owner_oh : '0;
  assign sent     = (!reset && state_q == S_WAIT && tx_done_tick) ? owner_oh : '0;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter. Two instances are used: one with
// MAX_BURST=4 (dut) and one with MAX_BURST=1 (dut_b1). Inputs are driven 1ns
// after the rising edge and outputs are sampled on the falling edge.
// Each observation is packed as {tx_start, tx_din, ack, sent, busy, owner}.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_done_tick;
  logic [3:0]  ack, sent;
  logic        tx_start, busy;
  logic [7:0]  tx_din;
  logic [1:0]  owner;

  logic [3:0]  r1_req;
  logic [31:0] r1_req_data;
  logic        r1_tx_done_tick;
  logic [3:0]  r1_ack, r1_sent;
  logic        r1_tx_start, r1_busy;
  logic [7:0]  r1_tx_din;
  logic [1:0]  r1_owner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .sent(sent), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done_tick(tx_done_tick), .busy(busy), .owner(owner)
  );

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .reset(reset), .req(r1_req), .req_data(r1_req_data),
    .ack(r1_ack), .sent(r1_sent), .tx_start(r1_tx_start), .tx_din(r1_tx_din),
    .tx_done_tick(r1_tx_done_tick), .busy(r1_busy), .owner(r1_owner)
  );

  logic [19:0] obs, obs1;
  assign obs  = {tx_start, tx_din, ack, sent, busy, owner};
  assign obs1 = {r1_tx_start, r1_tx_din, r1_ack, r1_sent, r1_busy, r1_owner};

  function automatic logic [19:0] pack(logic ts, logic [7:0] din, logic [3:0] a,
                                       logic [3:0] s, logic b, logic [1:0] o);
    return {ts, din, a, s, b, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_data = '0; tx_done_tick = 1'b0;
    r1_req = '0; r1_req_data = '0; r1_tx_done_tick = 1'b0;
    repeat (3) tick();
    sample();
    n_checks++;
    if (obs !== pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0)) begin
      n_fail++; $display("FAIL reset_hold got %h exp %h", obs, pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0));
    end
    tick();
    reset = 1'b0;
    sample();
    n_checks++;
    if (obs !== pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0)) begin
      n_fail++; $display("FAIL reset_release got %h exp %h", obs, pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0));
    end
    n_checks++;
    if (obs1 !== pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0)) begin
      n_fail++; $display("FAIL reset_release_b1 got %h exp %h", obs1, pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0));
    end
  endtask

  task automatic test_single();
    logic [19:0] e;
    tick();
    req = 4'b0100; req_data[23:16] = 8'hA5;
    sample();
    e = pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL single_req_cycle got %h exp %h", obs, e); end
    tick();
    req = 4'b0000;
    sample();
    e = pack(1, 8'hA5, 4'b0100, 4'b0, 1, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL single_launch got %h exp %h", obs, e); end
    tick();
    sample();
    e = pack(0, 8'hA5, 4'b0, 4'b0, 1, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL single_wait got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b1;
    sample();
    e = pack(0, 8'hA5, 4'b0, 4'b0100, 1, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL single_sent got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b0;
    sample();
    e = pack(0, 8'hA5, 4'b0, 4'b0, 0, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL single_idle_after got %h exp %h", obs, e); end
  endtask

  // MAX_BURST=1, all four requesting: order 0,1,2,3,0 with launch two
  // cycles after each done.
  task automatic test_round_robin();
    logic [19:0] e;
    logic [1:0]  o;
    logic [7:0]  d;
    tick();
    r1_req = 4'b1111;
    r1_req_data = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int k = 0; k < 5; k++) begin
      o = 2'(k % 4);
      d = 8'h40 + 8'(k % 4);
      tick();
      sample();
      e = pack(1, d, 4'b0001 << o, 4'b0, 1, o);
      n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL rr_launch_%0d got %h exp %h", k, obs1, e); end
      tick();
      tick();
      r1_tx_done_tick = 1'b1;
      sample();
      e = pack(0, d, 4'b0, 4'b0001 << o, 1, o);
      n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL rr_sent_%0d got %h exp %h", k, obs1, e); end
      tick();
      r1_tx_done_tick = 1'b0;
      if (k == 4) r1_req = 4'b0000;
      sample();
      e = pack(0, d, 4'b0, 4'b0, 0, o);
      n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL rr_gap_%0d got %h exp %h", k, obs1, e); end
    end
  endtask

  // MAX_BURST=4: requester 1 has six bytes, requester 3 one byte.
  task automatic test_burst();
    logic [19:0] e;
    logic [7:0]  b_din [7] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h33, 8'hB4, 8'hB5};
    logic [1:0]  b_own [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1};
    bit          b_cont[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1010;
    req_data[15:8] = 8'hB0;
    req_data[31:24] = 8'h33;
    tick();
    for (int j = 0; j < 7; j++) begin
      // Launch cycle: present the owner's next byte or drop its request.
      case (j)
        0: req_data[15:8] = 8'hB1;
        1: req_data[15:8] = 8'hB2;
        2: req_data[15:8] = 8'hB3;
        3: req_data[15:8] = 8'hB4;
        4: req[3] = 1'b0;
        5: req_data[15:8] = 8'hB5;
        default: req[1] = 1'b0;
      endcase
      sample();
      e = pack(1, b_din[j], 4'b0001 << b_own[j], 4'b0, 1, b_own[j]);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL burst_launch_%0d got %h exp %h", j, obs, e); end
      tick();
      tick();
      tx_done_tick = 1'b1;
      sample();
      e = pack(0, b_din[j], 4'b0, 4'b0001 << b_own[j], 1, b_own[j]);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL burst_sent_%0d got %h exp %h", j, obs, e); end
      tick();
      tx_done_tick = 1'b0;
      if (!b_cont[j]) begin
        sample();
        e = pack(0, b_din[j], 4'b0, 4'b0, 0, b_own[j]);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL burst_idle_%0d got %h exp %h", j, obs, e); end
        tick();
      end
    end
  endtask

  task automatic test_spurious_done();
    logic [19:0] e;
    tx_done_tick = 1'b1;
    sample();
    e = pack(0, 8'hB5, 4'b0, 4'b0, 0, 2'd1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL spur_idle got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b0;
    req = 4'b0001; req_data[7:0] = 8'h3C;
    sample();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL spur_idle_next got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b1;
    req = 4'b0000;
    sample();
    e = pack(1, 8'h3C, 4'b0001, 4'b0, 1, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL spur_launch got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b0;
    sample();
    e = pack(0, 8'h3C, 4'b0, 4'b0, 1, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL spur_wait got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b1;
    sample();
    e = pack(0, 8'h3C, 4'b0, 4'b0001, 1, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL spur_real_done got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b0;
    sample();
    e = pack(0, 8'h3C, 4'b0, 4'b0, 0, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL spur_end got %h exp %h", obs, e); end
  endtask

  task automatic test_reset_midframe();
    logic [19:0] e;
    tick();
    req = 4'b0100; req_data[23:16] = 8'h5A;
    tick();
    req = 4'b0000;
    sample();
    e = pack(1, 8'h5A, 4'b0100, 4'b0, 1, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstmid_launch got %h exp %h", obs, e); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_done_tick = 1'b1;
    req = 4'b1001; req_data[7:0] = 8'h01; req_data[31:24] = 8'h03;
    sample();
    e = pack(0, 8'h00, 4'b0, 4'b0, 0, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstmid_after got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b0;
    req = 4'b0000;
    sample();
    e = pack(1, 8'h01, 4'b0001, 4'b0, 1, 2'd0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstmid_tie got %h exp %h", obs, e); end
    tick();
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  // Requester 2 drops req the cycle after ack: one-byte grant, then the
  // 0-versus-3 tie goes to 3 because last_grant is 2.
  task automatic test_deassert();
    logic [19:0] e;
    tick();
    req = 4'b0100; req_data[23:16] = 8'hC3;
    tick();
    sample();
    e = pack(1, 8'hC3, 4'b0100, 4'b0, 1, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL deassert_launch got %h exp %h", obs, e); end
    tick();
    req = 4'b0000;
    tick();
    tx_done_tick = 1'b1;
    req = 4'b1001; req_data[7:0] = 8'h0A; req_data[31:24] = 8'h0D;
    sample();
    e = pack(0, 8'hC3, 4'b0, 4'b0100, 1, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL deassert_sent got %h exp %h", obs, e); end
    tick();
    tx_done_tick = 1'b0;
    sample();
    e = pack(0, 8'hC3, 4'b0, 4'b0, 0, 2'd2);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL deassert_ended got %h exp %h", obs, e); end
    tick();
    req = 4'b0000;
    sample();
    e = pack(1, 8'h0D, 4'b1000, 4'b0, 1, 2'd3);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL deassert_tie got %h exp %h", obs, e); end
    tick();
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_spurious_done();
    test_reset_midframe();
    test_deassert();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
